// File: rtl/rx_prbs_checker.sv
// PRBS-31 receive checker: reseeds on start of frame, compares each accepted word
// against the locally generated sequence, tracks lock and keeps saturating counters.
module rx_prbs_checker #(
    parameter int C_CNT_WIDTH    = 32,
    parameter int C_LOCK_WORDS   = 8,
    parameter int C_UNLOCK_WORDS = 4
) (
    input  logic                   i_aclk,
    input  logic                   i_areset,
    input  logic                   i_enable,
    input  logic                   i_clear,
    input  logic [31:0]            i_prbs_seed,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_sof,
    input  logic [31:0]            s_axis_tdata,
    output logic                   o_locked,
    output logic [C_CNT_WIDTH-1:0] o_bit_errors,
    output logic [C_CNT_WIDTH-1:0] o_err_words,
    output logic [C_CNT_WIDTH-1:0] o_words
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CHECK    = 2'd2
    } state_t;

    localparam logic [30:0]            LFSR_INIT = 31'h7FFF_FFFF;
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [7:0]             LOCK_N    = 8'(C_LOCK_WORDS);
    localparam logic [7:0]             UNLOCK_N  = 8'(C_UNLOCK_WORDS);

    // Advances the LFSR by 32 bit steps; returns {expected word, next state}.
    function automatic logic [62:0] prbs_step32(input logic [30:0] s_in);
        logic [30:0] s;
        logic [31:0] w;
        logic        n;
        s = s_in;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            n = s[30] ^ s[27];
            s = {s[29:0], n};
            w = {w[30:0], n};
        end
        return {w, s};
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] d_in);
        logic [31:0] d;
        logic [5:0]  c;
        d = d_in;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, d[0]};
            d = d >> 1;
        end
        return c;
    endfunction

    function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    function automatic logic [C_CNT_WIDTH-1:0] sat_add(input logic [C_CNT_WIDTH-1:0] cnt,
                                                       input logic [5:0]             inc);
        logic [C_CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + (C_CNT_WIDTH+1)'(inc);
        return sum[C_CNT_WIDTH] ? CNT_MAX : sum[C_CNT_WIDTH-1:0];
    endfunction

    function automatic logic [7:0] run_inc(input logic [7:0] r);
        return (r == 8'hFF) ? r : r + 8'd1;
    endfunction

    state_t      state;
    logic [30:0] lfsr;
    logic        accept;
    logic        check;
    logic [30:0] seed_eff;
    logic [30:0] lfsr_base;
    logic [31:0] exp_word;
    logic [30:0] lfsr_next;
    logic [31:0] diff_p1;
    logic        vld_p1;
    logic [5:0]  pop_p2;
    logic [7:0]  good_run;
    logic [7:0]  bad_run;
    logic [7:0]  good_next;
    logic [7:0]  bad_next;
    logic        unused_seed_msb;

    assign unused_seed_msb = i_prbs_seed[31];

    always_comb begin
        accept    = s_axis_tvalid & s_axis_tready;
        seed_eff  = (i_prbs_seed[30:0] == 31'd0) ? LFSR_INIT : i_prbs_seed[30:0];
        lfsr_base = s_axis_sof ? seed_eff : lfsr;
        {exp_word, lfsr_next} = prbs_step32(lfsr_base);
        check     = accept && ((state == CHECK) || (state == WAIT_SOF && s_axis_sof));
    end

    // Stage 0 -> 1: FSM, LFSR and the valid flag of the registered difference.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state         <= IDLE;
            lfsr          <= LFSR_INIT;
            s_axis_tready <= 1'b0;
            vld_p1        <= 1'b0;
        end else begin
            s_axis_tready <= i_enable;
            vld_p1        <= check;
            if (!i_enable) begin
                state <= IDLE;
                lfsr  <= LFSR_INIT;
            end else begin
                case (state)
                    IDLE: state <= WAIT_SOF;
                    WAIT_SOF: begin
                        if (accept && s_axis_sof) begin
                            state <= CHECK;
                            lfsr  <= lfsr_next;
                        end
                    end
                    CHECK: begin
                        if (accept) lfsr <= lfsr_next;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (check) diff_p1 <= s_axis_tdata ^ exp_word;
    end

    always_comb begin
        pop_p2 = popcount32(diff_p1);
        if (pop_p2 != 6'd0) begin
            good_next = 8'd0;
            bad_next  = run_inc(bad_run);
        end else begin
            good_next = run_inc(good_run);
            bad_next  = 8'd0;
        end
    end

    // Stage 1 -> 2: counters and lock tracking. Words already in flight still count
    // after disable, but lock state is forced clear while disabled.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            o_bit_errors <= '0;
            o_err_words  <= '0;
            o_words      <= '0;
            o_locked     <= 1'b0;
            good_run     <= 8'd0;
            bad_run      <= 8'd0;
        end else begin
            if (i_clear) begin
                o_bit_errors <= '0;
                o_err_words  <= '0;
                o_words      <= '0;
            end else if (vld_p1) begin
                o_words      <= sat_inc(o_words);
                o_bit_errors <= sat_add(o_bit_errors, pop_p2);
                if (pop_p2 != 6'd0) o_err_words <= sat_inc(o_err_words);
            end
            if (!i_enable) begin
                o_locked <= 1'b0;
                good_run <= 8'd0;
                bad_run  <= 8'd0;
            end else if (vld_p1) begin
                good_run <= good_next;
                bad_run  <= bad_next;
                if (!o_locked && good_next >= LOCK_N)
                    o_locked <= 1'b1;
                else if (o_locked && bad_next >= UNLOCK_N)
                    o_locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_prbs_checker.sv
// Bench for rx_prbs_checker: directed steps plus randomized traffic, checked against a
// frame-indexed PRBS reference model; a second instance uses 8-bit counters for saturation.
module tb_rx_prbs_checker;

    localparam int LOCK_W   = 8;
    localparam int UNLOCK_W = 4;

    logic        clk = 1'b0;
    logic        i_areset;
    logic        i_enable;
    logic        i_clear;
    logic [31:0] s_seed;
    logic        s_axis_tvalid;
    logic        s_axis_sof;
    logic [31:0] s_axis_tdata;

    logic        tready32, locked32;
    logic [31:0] bits32, errw32, words32;
    logic        tready8, locked8;
    logic [7:0]  bits8, errw8, words8;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // reference model state: a frame is identified by its seed and a word index
    int          m_mode;
    logic [31:0] m_seed;
    int          m_idx;
    longint      m_words, m_bits, m_errw;
    logic        m_locked;
    int          m_good, m_bad;

    logic [31:0] fseed;
    int          fidx;

    always #5 clk = ~clk;

    rx_prbs_checker #(.C_CNT_WIDTH(32), .C_LOCK_WORDS(LOCK_W), .C_UNLOCK_WORDS(UNLOCK_W)) dut (
        .i_aclk(clk), .i_areset(i_areset), .i_enable(i_enable), .i_clear(i_clear),
        .i_prbs_seed(s_seed), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready32),
        .s_axis_sof(s_axis_sof), .s_axis_tdata(s_axis_tdata), .o_locked(locked32),
        .o_bit_errors(bits32), .o_err_words(errw32), .o_words(words32)
    );

    rx_prbs_checker #(.C_CNT_WIDTH(8), .C_LOCK_WORDS(LOCK_W), .C_UNLOCK_WORDS(UNLOCK_W)) dut8 (
        .i_aclk(clk), .i_areset(i_areset), .i_enable(i_enable), .i_clear(i_clear),
        .i_prbs_seed(s_seed), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready8),
        .s_axis_sof(s_axis_sof), .s_axis_tdata(s_axis_tdata), .o_locked(locked8),
        .o_bit_errors(bits8), .o_err_words(errw8), .o_words(words8)
    );

    // Word idx (0-based) of the PRBS-31 frame started from seed, regenerated from scratch.
    // The history queue holds the last 31 generated bits, oldest first.
    function automatic logic [31:0] prbs_frame(input logic [31:0] seed, input int idx);
        bit          h[$];
        bit          nb;
        logic [30:0] s;
        logic [31:0] w;
        s = seed[30:0];
        if (s == 31'd0) s = 31'h7FFF_FFFF;
        for (int i = 30; i >= 0; i--) h.push_back(s[i]);
        w = '0;
        for (int k = 0; k < 32 * (idx + 1); k++) begin
            nb = h[0] ^ h[3];
            void'(h.pop_front());
            h.push_back(nb);
            w = {w[30:0], nb};
        end
        return w;
    endfunction

    function automatic logic [63:0] satw(input longint v, input int w);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
        return (64'(v) > mx) ? mx : 64'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_words32"}, 64'(words32), satw(m_words, 32));
        chk({tag, "_bits32"},  64'(bits32),  satw(m_bits, 32));
        chk({tag, "_errw32"},  64'(errw32),  satw(m_errw, 32));
        chk({tag, "_words8"},  64'(words8),  satw(m_words, 8));
        chk({tag, "_bits8"},   64'(bits8),   satw(m_bits, 8));
        chk({tag, "_errw8"},   64'(errw8),   satw(m_errw, 8));
        chk({tag, "_lock32"},  64'(locked32), 64'(m_locked));
        chk({tag, "_lock8"},   64'(locked8),  64'(m_locked));
    endtask

    task automatic m_reset();
        m_mode = 0; m_locked = 1'b0; m_good = 0; m_bad = 0;
        m_words = 0; m_bits = 0; m_errw = 0; m_idx = 0; m_seed = '0;
    endtask

    task automatic m_accept(input logic sof, input logic [31:0] data);
        int pop;
        if (m_mode == 0) return;
        if (m_mode == 1 && !sof) return;
        if (sof) begin
            m_seed = s_seed;
            m_idx  = 0;
            m_mode = 2;
        end
        pop = $countones(data ^ prbs_frame(m_seed, m_idx));
        m_idx++;
        m_words++;
        m_bits += pop;
        if (pop != 0) begin
            m_errw++;
            m_good = 0;
            m_bad  = (m_bad < 255) ? m_bad + 1 : 255;
            if (m_locked && m_bad >= UNLOCK_W) m_locked = 1'b0;
        end else begin
            m_bad  = 0;
            m_good = (m_good < 255) ? m_good + 1 : 255;
            if (!m_locked && m_good >= LOCK_W) m_locked = 1'b1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sof, input logic [31:0] data);
        chk("tready_before_send", 64'(tready32), 64'd1);
        s_axis_tvalid = 1'b1;
        s_axis_sof    = sof;
        s_axis_tdata  = data;
        step(1);
        m_accept(sof, data);
        s_axis_tvalid = 1'b0;
        s_axis_sof    = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] seed);
        s_seed = seed;
        fseed  = seed;
        fidx   = 0;
    endtask

    task automatic send_next(input logic [31:0] err_mask);
        send(fidx == 0, prbs_frame(fseed, fidx) ^ err_mask);
        fidx++;
    endtask

    task automatic set_enable(input logic en);
        i_enable = en;
        step(1);
        if (en) begin
            if (m_mode == 0) m_mode = 1;
        end else begin
            m_mode = 0; m_locked = 1'b0; m_good = 0; m_bad = 0;
        end
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        m_words = 0; m_bits = 0; m_errw = 0;
    endtask

    initial begin
        logic [31:0] data;
        logic        sof;
        int          r;

        i_areset = 1'b1; i_enable = 1'b0; i_clear = 1'b0; s_seed = '0;
        s_axis_tvalid = 1'b0; s_axis_sof = 1'b0; s_axis_tdata = '0;
        fseed = '0; fidx = 0;
        m_reset();
        step(3);
        chk("reset_tready32", 64'(tready32), 64'd0);
        chk("reset_tready8",  64'(tready8),  64'd0);
        chk_state("reset");
        i_areset = 1'b0;
        step(1);
        chk("idle_tready", 64'(tready32), 64'd0);

        set_enable(1'b1);
        chk("enable_tready", 64'(tready32), 64'd1);

        // 16 correct words from seed 1; lock appears two cycles after the 8th acceptance
        start_frame(32'h0000_0001);
        for (int i = 0; i < 16; i++) begin
            send_next(32'd0);
            if (i == 7) chk("lock_not_yet", 64'(locked32), 64'd0);
            if (i == 8) chk("lock_after_8", 64'(locked32), 64'd1);
        end
        step(3);
        chk_state("clean_frame");
        chk("clean_words_abs", 64'(words32), 64'd16);

        // clear leaves lock alone; then same frame with bit 0 of word 5 flipped
        pulse_clear();
        chk_state("after_clear");
        start_frame(32'h0000_0001);
        for (int i = 0; i < 16; i++) send_next((i == 5) ? 32'h1 : 32'h0);
        step(3);
        chk_state("one_bit_err");
        chk("one_bit_err_abs", 64'(bits32), 64'd1);

        // 4 fully inverted words drop lock, 8 correct words regain it
        for (int i = 0; i < 4; i++) send_next(32'hFFFF_FFFF);
        step(3);
        chk_state("inverted4");
        chk("inverted4_bits_abs", 64'(bits32), 64'd129);
        for (int i = 0; i < 8; i++) send_next(32'd0);
        step(3);
        chk_state("relock");

        // a word still in flight when enable falls is counted; lock clears
        send_next(32'hF000_000F);
        set_enable(1'b0);
        chk("disable_tready", 64'(tready32), 64'd0);
        step(2);
        chk_state("disabled");
        pulse_clear();
        set_enable(1'b1);

        // non-sof words before the first sof are discarded; mid-frame seed change ignored
        s_seed = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) send(1'b0, $urandom);
        step(3);
        chk_state("pre_sof_discard");
        start_frame(32'h1234_5678);
        for (int i = 0; i < 6; i++) begin
            send_next(32'd0);
            if (i == 2) s_seed = 32'hFFFF_0000;
        end
        start_frame(32'h0000_0000);
        for (int i = 0; i < 6; i++) send_next(32'd0);
        step(3);
        chk_state("reseed");

        // 9 inverted words saturate the 8-bit bit-error counter; clear zeroes everything
        pulse_clear();
        start_frame($urandom);
        for (int i = 0; i < 9; i++) send_next(32'hFFFF_FFFF);
        step(3);
        chk_state("saturate");
        chk("saturate_bits8_abs", 64'(bits8), 64'd255);
        pulse_clear();
        chk_state("sat_cleared");

        // randomized traffic: gaps, random reseeds, random error masks
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
            sof = (n == 0) || ($urandom_range(0, 14) == 0);
            if (sof) start_frame(($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
            data = prbs_frame(fseed, fidx);
            fidx++;
            r = $urandom_range(0, 9);
            if (r == 0) data = ~data;
            else if (r < 3) data = data ^ $urandom;
            send(sof, data);
            if (n % 20 == 19) begin
                step(3);
                chk_state("random");
            end
        end
        step(3);
        chk_state("random_end");

        // reset with words in the pipeline discards them
        start_frame($urandom);
        for (int i = 0; i < 10; i++) send_next(32'd0);
        chk("pre_reset_lock", 64'(locked32), 64'd1);
        i_areset = 1'b1;
        step(1);
        m_reset();
        chk("areset_tready", 64'(tready32), 64'd0);
        chk_state("areset");
        i_enable = 1'b0;
        i_areset = 1'b0;
        step(3);
        chk_state("areset_no_late");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
